// File: rtl/error_collector.sv
// Error collector: stores per-sample errors in a result RAM and tracks sum/peak of |error|.
// Latency: statistics and RAM write update one cycle after acceptance; rd_data is 1-cycle registered.
// Backpressure: none -- every valid sample is either accepted or dropped in the cycle it arrives.
module error_collector #(
  parameter int N_SAMPLES = 150,
  parameter int WIDTH     = 20,
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              err_valid,
  input  logic [WIDTH-1:0]  err_in,
  input  logic [ADDR_W-1:0] err_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ACC_W-1:0]  sum_abs,
  output logic [WIDTH-1:0]  max_abs,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One extra bit so the limit is representable even when N_SAMPLES == 2**ADDR_W.
  localparam logic [ADDR_W:0]   N_LIMIT    = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_COUNT = ADDR_W'(N_SAMPLES - 1);
  localparam logic [WIDTH-1:0]  MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  MOST_POS   = {1'b0, {(WIDTH-1){1'b1}}};

  state_t            state;
  logic [WIDTH-1:0]  mem [0:N_SAMPLES-1];
  logic [WIDTH-1:0]  abs_val;
  logic              wr_addr_ok;
  logic              rd_addr_ok;
  logic              take;
  logic              accept;
  logic              reject;

  // Address range checks against the RAM depth.
  assign wr_addr_ok = ({1'b0, err_addr} < N_LIMIT);
  assign rd_addr_ok = ({1'b0, rd_addr} < N_LIMIT);

  // A start pulse always wins over a sample arriving in the same cycle.
  assign take   = (state == COLLECT) && err_valid && !start;
  assign accept = take && wr_addr_ok;
  assign reject = take && !wr_addr_ok;

  // Absolute value; the most negative code has no positive twin, so it saturates.
  always_comb begin
    abs_val = err_in;
    if (err_in[WIDTH-1]) begin
      if (err_in == MOST_NEG) begin
        abs_val = MOST_POS;
      end else begin
        abs_val = {WIDTH{1'b0}} - err_in;
      end
    end
  end

  // Control FSM with registered status and statistics outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      sum_abs  <= '0;
      max_abs  <= '0;
      max_addr <= '0;
      addr_err <= 1'b0;
    end else if (start) begin
      // Restart from any state; RAM contents are deliberately kept.
      state    <= COLLECT;
      busy     <= 1'b1;
      done     <= 1'b0;
      count    <= '0;
      sum_abs  <= '0;
      max_abs  <= '0;
      max_addr <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            count   <= count + ADDR_W'(1);
            sum_abs <= sum_abs + ACC_W'(abs_val);
            // Strictly greater: on a tie the earlier address is kept.
            if (abs_val > max_abs) begin
              max_abs  <= abs_val;
              max_addr <= err_addr;
            end
            // The edge that completes the run also raises done.
            if (count == LAST_COUNT) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          if (reject) begin
            addr_err <= 1'b1;
          end
        end
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Result RAM write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[err_addr] <= err_in;
    end
  end

  // Registered readback; a same-cycle write is not forwarded, so the old word is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr_ok) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_error_collector.sv
// Directed bench for error_collector: reset, full run, sign/peak handling, bad addresses,
// start collisions and RAM readback, with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_error_collector;

  localparam int WIDTH  = 20;
  localparam int ADDR_W = 8;
  localparam int ACC_W  = 28;

  logic              clk;
  logic              rst;
  logic              start;
  logic              err_valid;
  logic [WIDTH-1:0]  err_in;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [ACC_W-1:0]  sum_abs;
  logic [WIDTH-1:0]  max_abs;
  logic [ADDR_W-1:0] max_addr;
  logic [ADDR_W-1:0] count;
  logic              busy;
  logic              done;
  logic              addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  error_collector #(
    .N_SAMPLES(150),
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .ACC_W    (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .err_valid(err_valid),
    .err_in   (err_in),
    .err_addr (err_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .sum_abs  (sum_abs),
    .max_abs  (max_abs),
    .max_addr (max_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] e);
    err_valid = 1'b1;
    err_addr  = a;
    err_in    = e;
    tick();
    err_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".done"},     32'(done),     32'd0);
    check({tag, ".count"},    32'(count),    32'd0);
    check({tag, ".sum"},      32'(sum_abs),  32'd0);
    check({tag, ".max_abs"},  32'(max_abs),  32'd0);
    check({tag, ".max_addr"}, 32'(max_addr), 32'd0);
    check({tag, ".addr_err"}, 32'(addr_err), 32'd0);
    check({tag, ".rd_data"},  32'(rd_data),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    err_valid = 1'b0;
    err_in    = '0;
    err_addr  = '0;
    rd_addr   = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // T1: ten samples of +2, then asynchronous reset between edges.
    do_start();
    check("t1.busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) send(ADDR_W'(i), 20'd2);
    check("t1.count", 32'(count),   32'd10);
    check("t1.sum",   32'(sum_abs), 32'd20);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t1.async_rst");
    tick();
    rst = 1'b0;
    tick();

    // T2: full run of 150 samples of +1.
    do_start();
    for (int i = 0; i < 150; i++) begin
      if (i == 149) check("t2.not_done_yet", 32'(done), 32'd0);
      send(ADDR_W'(i), 20'd1);
    end
    check("t2.count",    32'(count),    32'd150);
    check("t2.sum",      32'(sum_abs),  32'd150);
    check("t2.done",     32'(done),     32'd1);
    check("t2.busy",     32'(busy),     32'd0);
    check("t2.max_abs",  32'(max_abs),  32'd1);
    check("t2.max_addr", 32'(max_addr), 32'd0);

    // T6: readback after the full run.
    rd_addr = 8'd37;
    tick();
    check("t6.rd37", 32'(rd_data), 32'd1);
    rd_addr = 8'd149;
    tick();
    check("t6.rd149", 32'(rd_data), 32'd1);
    rd_addr = 8'd150;
    tick();
    check("t6.rd150", 32'(rd_data), 32'd0);

    // T5b: samples in DONE are ignored.
    send(8'd5, 20'd100);
    check("t5.done_count", 32'(count),   32'd150);
    check("t5.done_sum",   32'(sum_abs), 32'd150);
    check("t5.done_held",  32'(done),    32'd1);

    // T3: signs, saturation and peak.
    do_start();
    check("t3.cleared_sum", 32'(sum_abs), 32'd0);
    check("t3.done_low",    32'(done),    32'd0);
    send(8'd0, 20'd5);
    send(8'd1, 20'hFFFF7);
    check("t3.max_after_neg",  32'(max_abs),  32'd9);
    check("t3.addr_after_neg", 32'(max_addr), 32'd1);
    send(8'd2, 20'd9);
    send(8'd3, 20'h80000);
    check("t3.sum",      32'(sum_abs),  32'd524310);
    check("t3.max_abs",  32'(max_abs),  32'h7FFFF);
    check("t3.max_addr", 32'(max_addr), 32'd3);
    check("t3.count",    32'(count),    32'd4);

    // T3 rerun: tie at 9 keeps address 1.
    do_start();
    send(8'd0, 20'd5);
    send(8'd1, 20'hFFFF7);
    send(8'd2, 20'd9);
    check("t3r.sum",      32'(sum_abs),  32'd23);
    check("t3r.max_abs",  32'(max_abs),  32'd9);
    check("t3r.max_addr", 32'(max_addr), 32'd1);
    rd_addr = 8'd1;
    tick();
    check("t3r.rd1_neg", 32'(rd_data), 32'hFFFF7);
    rd_addr = 8'd3;
    tick();
    check("t3r.rd3_kept", 32'(rd_data), 32'h80000);

    // T4: out-of-range addresses.
    send(8'd200, 20'd7);
    check("t4.addr_err", 32'(addr_err), 32'd1);
    check("t4.count",    32'(count),    32'd3);
    check("t4.sum",      32'(sum_abs),  32'd23);
    send(8'd150, 20'd7);
    check("t4.edge_count", 32'(count),   32'd3);
    check("t4.edge_sum",   32'(sum_abs), 32'd23);

    // T5a: start mid-run with a colliding sample; start wins and clears addr_err.
    start     = 1'b1;
    err_valid = 1'b1;
    err_addr  = 8'd0;
    err_in    = 20'd50;
    tick();
    start     = 1'b0;
    err_valid = 1'b0;
    check("t5.count",    32'(count),    32'd0);
    check("t5.sum",      32'(sum_abs),  32'd0);
    check("t5.busy",     32'(busy),     32'd1);
    check("t5.addr_err", 32'(addr_err), 32'd0);
    rd_addr = 8'd0;
    tick();
    check("t5.rd0_not_written", 32'(rd_data), 32'd5);

    // Read-during-write returns the old word, new word one cycle later.
    send(8'd0, 20'd33);
    check("rdw.old", 32'(rd_data), 32'd5);
    tick();
    check("rdw.new", 32'(rd_data), 32'd33);
    check("rdw.count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
